audio_stream_buffer: RTL and testbench

//  Upstream feeder for the I2S transmitter. Assembles a byte stream (UART RX) into
//  24-bit two's-complement mono samples and buffers them in a FIFO. Releases one

---
 rtl/audio_stream_buffer_if.sv | 22 ++
 rtl/audio_stream_buffer.sv | 141 ++++++++++++++
 tb/tb_audio_stream_buffer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_stream_buffer_if.sv
// Byte-stream handshake into the audio sample buffer.
// The master side feeds bytes and the resync pulse; the slave side returns back-pressure.
interface audio_stream_buffer_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic       sync_clr;

    modport master (
        output byte_data,
        output byte_valid,
        output sync_clr,
        input  byte_ready
    );

    modport slave (
        input  byte_data,
        input  byte_valid,
        input  sync_clr,
        output byte_ready
    );
endinterface

// File: rtl/audio_stream_buffer.sv
// Audio stream buffer: assembles little-endian bytes into 24-bit mono samples, queues them
// in a FIFO and releases one sample per sample-rate tick once the prefill level is reached.
module audio_stream_buffer #(
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned PREFILL      = 128,
    parameter int unsigned TICK_DIV     = 281,
    parameter int unsigned AFULL_MARGIN = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    audio_stream_buffer_if.slave     bus,
    output logic [23:0]              mono_sample_o,
    output logic                     sample_tick_o,
    output logic                     playing_o,
    output logic                     almost_full_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [15:0]              underrun_count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [LW-1:0] PrefillLvl = LW'(PREFILL);
    localparam logic [LW-1:0] AfullLvl   = LW'(DEPTH - AFULL_MARGIN);
    localparam logic [LW-1:0] FullLvl    = LW'(DEPTH);
    localparam logic [CW-1:0] TickMax    = CW'(TICK_DIV - 1);

    typedef enum logic {StPrefill, StPlay} state_e;

    state_e        state_q;
    logic [23:0]   mono_sample_q;
    logic          sample_tick_q;
    logic          playing_q;
    logic [15:0]   underrun_q;

    logic [1:0]    phase_q;
    logic [7:0]    b0_q, b1_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          byte_ready_q;
    logic [CW-1:0] tick_cnt_q;
    logic [23:0]   mem_q [DEPTH];

    logic tick, accept, push, pop, empty;

    assign tick   = (tick_cnt_q == TickMax);
    // sync_clr overrides a byte offered in the same cycle
    assign accept = bus.byte_valid && byte_ready_q && !bus.sync_clr;
    assign push   = accept && (phase_q == 2'd2);
    assign empty  = (level_q == '0);
    assign pop    = (state_q == StPlay) && tick && !empty;

    // Occupancy after this cycle's push/pop
    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Byte assembly, FIFO pointers, occupancy, back-pressure and tick divider
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q      <= 2'd0;
            b0_q         <= 8'd0;
            b1_q         <= 8'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            byte_ready_q <= 1'b0;
            tick_cnt_q   <= '0;
        end else begin
            if (bus.sync_clr) begin
                phase_q <= 2'd0;
            end else if (accept) begin
                phase_q <= (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
                if (phase_q == 2'd0) b0_q <= bus.byte_data;
                if (phase_q == 2'd1) b1_q <= bus.byte_data;
            end
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
            // Ready tracks registered fullness; a same-cycle pop does not reopen it early
            byte_ready_q <= (level_d != FullLvl);
            tick_cnt_q   <= tick ? '0 : tick_cnt_q + CW'(1);
        end
    end

    // Sample storage; no reset needed, occupancy tracks validity
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.byte_data, b1_q, b0_q};
    end

    // Playback FSM with registered sample, tick pulse, playing flag and underrun counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StPrefill;
            mono_sample_q <= 24'd0;
            sample_tick_q <= 1'b0;
            playing_q     <= 1'b0;
            underrun_q    <= 16'd0;
        end else begin
            sample_tick_q <= 1'b0;
            unique case (state_q)
                StPrefill: begin
                    mono_sample_q <= 24'd0;
                    if (level_q >= PrefillLvl) begin
                        state_q   <= StPlay;
                        playing_q <= 1'b1;
                    end
                end
                StPlay: begin
                    if (tick) begin
                        sample_tick_q <= 1'b1;
                        if (!empty) begin
                            mono_sample_q <= mem_q[rd_ptr_q];
                        end else begin
                            mono_sample_q <= 24'd0;
                            if (underrun_q != 16'hFFFF) underrun_q <= underrun_q + 16'd1;
                            state_q   <= StPrefill;
                            playing_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= StPrefill;
            endcase
        end
    end

    assign bus.byte_ready   = byte_ready_q;
    assign mono_sample_o    = mono_sample_q;
    assign sample_tick_o    = sample_tick_q;
    assign playing_o        = playing_q;
    assign almost_full_o    = (level_q >= AfullLvl);
    assign level_o          = level_q;
    assign underrun_count_o = underrun_q;

endmodule

// File: tb/tb_audio_stream_buffer.sv
// Directed bench for audio_stream_buffer: three instances with different parameters share
// the byte stream; the ones not under test are held in reset.
module tb_audio_stream_buffer;

    localparam int TdA = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, rst_c;
    logic [7:0] bd;
    logic       bv, sc;
    int         sel;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc_a;

    audio_stream_buffer_if if_a ();
    audio_stream_buffer_if if_b ();
    audio_stream_buffer_if if_c ();

    assign if_a.byte_data = bd; assign if_a.byte_valid = bv; assign if_a.sync_clr = sc;
    assign if_b.byte_data = bd; assign if_b.byte_valid = bv; assign if_b.sync_clr = sc;
    assign if_c.byte_data = bd; assign if_c.byte_valid = bv; assign if_c.sync_clr = sc;

    logic [23:0] mono_a, mono_b, mono_c;
    logic        stk_a, stk_b, stk_c, play_a, play_b, play_c, af_a, af_b, af_c;
    logic [4:0]  lvl_a;
    logic [8:0]  lvl_b, lvl_c;
    logic [15:0] ur_a, ur_b, ur_c;

    audio_stream_buffer #(.DEPTH(16), .PREFILL(1), .TICK_DIV(TdA), .AFULL_MARGIN(4)) u_a (
        .clk(clk), .rst(rst_a), .bus(if_a), .mono_sample_o(mono_a), .sample_tick_o(stk_a),
        .playing_o(play_a), .almost_full_o(af_a), .level_o(lvl_a), .underrun_count_o(ur_a)
    );
    audio_stream_buffer #(.DEPTH(256), .PREFILL(128), .TICK_DIV(20), .AFULL_MARGIN(16)) u_b (
        .clk(clk), .rst(rst_b), .bus(if_b), .mono_sample_o(mono_b), .sample_tick_o(stk_b),
        .playing_o(play_b), .almost_full_o(af_b), .level_o(lvl_b), .underrun_count_o(ur_b)
    );
    audio_stream_buffer #(.DEPTH(256), .PREFILL(256), .TICK_DIV(1000), .AFULL_MARGIN(16)) u_c (
        .clk(clk), .rst(rst_c), .bus(if_c), .mono_sample_o(mono_c), .sample_tick_o(stk_c),
        .playing_o(play_c), .almost_full_o(af_c), .level_o(lvl_c), .underrun_count_o(ur_c)
    );

    // Edges since instance A left reset; equals its tick counter modulo TdA
    always @(posedge clk) begin
        if (rst_a) cyc_a <= 0;
        else       cyc_a <= cyc_a + 1;
    end

    function automatic logic cur_ready();
        case (sel)
            0:       return if_a.byte_ready;
            1:       return if_b.byte_ready;
            default: return if_c.byte_ready;
        endcase
    endfunction

    function automatic logic cur_stick();
        case (sel)
            0:       return stk_a;
            1:       return stk_b;
            default: return stk_c;
        endcase
    endfunction

    function automatic logic [23:0] v_b(input int j);
        return 24'(j * 24'h010203 + 24'h00A5C3);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n  = 0;
        bd = b;
        bv = 1'b1;
        while (!cur_ready() && n < 3000) begin
            step();
            n++;
        end
        check("byte_accept_wait", 32'(cur_ready()), 32'd1);
        step();
        bv = 1'b0;
    endtask

    task automatic send_sample(input logic [23:0] v);
        send_byte(v[7:0]);
        send_byte(v[15:8]);
        send_byte(v[23:16]);
    endtask

    task automatic wait_stick();
        int n;
        n = 0;
        while (!cur_stick() && n < 3000) begin
            step();
            n++;
        end
        check("sample_tick_wait", 32'(cur_stick()), 32'd1);
    endtask

    // Return just after an A tick edge, leaving TdA-1 cycles before the next tick
    task automatic align_a();
        int n;
        n = 0;
        while ((cyc_a % TdA) != 1 && n < 100) begin
            step();
            n++;
        end
    endtask

    initial begin
        int ticks;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        bd = 8'd0; bv = 1'b0; sc = 1'b0; sel = 0;
        step(); step();

        // Reset values and release on instance A
        check("a_rst_ready", 32'(if_a.byte_ready), 32'd0);
        check("a_rst_mono", 32'(mono_a), 32'd0);
        check("a_rst_level", 32'(lvl_a), 32'd0);
        rst_a = 1'b0;
        check("a_rel_ready_now", 32'(if_a.byte_ready), 32'd0);
        step();
        check("a_rel_ready_next", 32'(if_a.byte_ready), 32'd1);

        // PREFILL=1 basic assembly
        align_a();
        send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        check("a_level_1", 32'(lvl_a), 32'd1);
        check("a_play_pre", 32'(play_a), 32'd0);
        step();
        check("a_play_post", 32'(play_a), 32'd1);
        wait_stick();
        check("a_mono_123456", 32'(mono_a), 32'h123456);
        step();
        check("a_stick_1cyc", 32'(stk_a), 32'd0);
        check("a_mono_hold", 32'(mono_a), 32'h123456);
        send_sample(24'hFFFFFF);
        wait_stick();
        check("a_mono_ffffff", 32'(mono_a), 32'hFFFFFF);

        // Underrun after two samples, then resume
        align_a();
        send_sample(24'h0A0B0C);
        send_sample(24'h0D0E0F);
        check("a_level_2", 32'(lvl_a), 32'd2);
        wait_stick();
        check("a_ur_s1", 32'(mono_a), 32'h0A0B0C);
        step();
        wait_stick();
        check("a_ur_s2", 32'(mono_a), 32'h0D0E0F);
        step();
        wait_stick();
        check("a_ur_zero", 32'(mono_a), 32'd0);
        check("a_ur_count", 32'(ur_a), 32'd1);
        check("a_ur_play", 32'(play_a), 32'd0);
        align_a();
        send_sample(24'h112233);
        step();
        check("a_resume_play", 32'(play_a), 32'd1);
        wait_stick();
        check("a_resume_mono", 32'(mono_a), 32'h112233);

        // sync_clr discards partial bytes
        align_a();
        send_byte(8'hAA);
        sc = 1'b1; step(); sc = 1'b0;
        send_byte(8'h03); send_byte(8'h02); send_byte(8'h01);
        wait_stick();
        check("a_sync_partial", 32'(mono_a), 32'h010203);
        // sync_clr together with a byte discards that byte
        align_a();
        bd = 8'h77; bv = 1'b1; sc = 1'b1; step(); bv = 1'b0; sc = 1'b0;
        send_byte(8'h06); send_byte(8'h05); send_byte(8'h04);
        wait_stick();
        check("a_sync_same_cyc", 32'(mono_a), 32'h040506);
        check("a_ur_count_end", 32'(ur_a), 32'd1);
        rst_a = 1'b1;

        // PREFILL=128 threshold and FIFO order on instance B
        sel = 1;
        rst_b = 1'b0;
        step();
        for (int j = 0; j < 127; j++) send_sample(v_b(j));
        check("b_level_127", 32'(lvl_b), 32'd127);
        ticks = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (stk_b) ticks++;
        end
        check("b_prefill_ticks", 32'(ticks), 32'd0);
        check("b_prefill_mono", 32'(mono_b), 32'd0);
        check("b_prefill_play", 32'(play_b), 32'd0);
        send_sample(v_b(127));
        check("b_level_128", 32'(lvl_b), 32'd128);
        step();
        check("b_play", 32'(play_b), 32'd1);
        for (int j = 0; j < 4; j++) begin
            wait_stick();
            check("b_order", 32'(mono_b), 32'(v_b(j)));
            step();
        end

        // Reset mid-stream on B while playing with a partial sample
        send_byte(8'h99);
        #2 rst_b = 1'b1;
        #1;
        check("b_rst_level", 32'(lvl_b), 32'd0);
        check("b_rst_play", 32'(play_b), 32'd0);
        check("b_rst_mono", 32'(mono_b), 32'd0);
        check("b_rst_stick", 32'(stk_b), 32'd0);
        check("b_rst_ready", 32'(if_b.byte_ready), 32'd0);
        step(); step();
        check("b_rst_ready_hold", 32'(if_b.byte_ready), 32'd0);
        rst_b = 1'b0;
        step();
        check("b_rel_ready", 32'(if_b.byte_ready), 32'd1);
        check("b_rel_play", 32'(play_b), 32'd0);
        send_byte(8'h01); send_byte(8'h02);
        check("b_phase_lvl0", 32'(lvl_b), 32'd0);
        send_byte(8'h03);
        check("b_phase_lvl1", 32'(lvl_b), 32'd1);
        rst_b = 1'b1;

        // Full FIFO and back-pressure on instance C
        sel = 2;
        rst_c = 1'b0;
        step();
        for (int k = 0; k < 768; k++) begin
            send_byte(8'(k));
            if (k == 718) check("c_af_239", 32'(af_c), 32'd0);
            if (k == 719) check("c_af_240", 32'(af_c), 32'd1);
        end
        check("c_full_level", 32'(lvl_c), 32'd256);
        check("c_full_ready", 32'(if_c.byte_ready), 32'd0);
        bd = 8'd0; bv = 1'b1;
        ticks = 0;
        while (!if_c.byte_ready && ticks < 1500) begin
            step();
            ticks++;
        end
        check("c_pop_ready", 32'(if_c.byte_ready), 32'd1);
        check("c_pop_level", 32'(lvl_c), 32'd255);
        check("c_pop_mono", 32'(mono_c), 32'h020100);
        check("c_pop_play", 32'(play_c), 32'd1);
        step();
        bv = 1'b0;
        send_byte(8'd1); send_byte(8'd2);
        check("c_refull_level", 32'(lvl_c), 32'd256);
        check("c_refull_ready", 32'(if_c.byte_ready), 32'd0);
        send_byte(8'd3); send_byte(8'd4);
        check("c_pop2_mono", 32'(mono_c), 32'h050403);
        check("c_pop2_level", 32'(lvl_c), 32'd255);
        rst_c = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
